// File: rtl/rr_op_sequencer.sv
// Control sequencer for the register-register datapath: runs either an MDR preload
// or the T0..T6 fetch/execute sequence, with every datapath strobe registered.
module rr_op_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 4,
    parameter int SEL_W    = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              mode,
    input  logic [4:0]        ra,
    input  logic [4:0]        rb,
    input  logic [4:0]        rc,
    input  logic [CTRL_W-1:0] alu_op,
    input  logic              wide,
    input  logic [DATA_W-1:0] load_data,
    output logic [SEL_W-1:0]  enable,
    output logic [SEL_W-1:0]  bus_select,
    output logic              md_read,
    output logic              inc_pc,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] mdata_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state | meaning
    // IDLE  | waiting for start; done pulses here after a sequence
    // LA    | preload: memory data into MDR
    // LB    | preload: MDR onto bus, write R[ra]
    // T0    | PC to MAR, increment PC
    // T1    | memory read into MDR
    // T2    | MDR to IR
    // T3    | R[rb] to Y
    // T4    | R[rc] through ALU into Z
    // T5    | Zlo to R[ra] (or LO when wide)
    // T6    | Zhi to HI (wide only)
    typedef enum logic [3:0] {
        S_IDLE, S_LA, S_LB, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    localparam int EN_HI  = 16;
    localparam int EN_LO  = 17;
    localparam int BS_ZHI = 18;
    localparam int BS_ZLO = 19;
    localparam int B_PC   = 20;
    localparam int B_MDR  = 21;
    localparam int EN_IR  = 23;
    localparam int EN_Z   = 24;
    localparam int EN_MAR = 25;
    localparam int EN_Y   = 27;
    localparam logic [5:0] NREGS = 6'(NUM_REGS);

    state_t state, state_nxt;

    logic [4:0]        ra_q, rb_q, rc_q;
    logic [CTRL_W-1:0] op_q;
    logic              wide_q;
    logic [DATA_W-1:0] data_q;

    logic              accept, bad;
    logic [4:0]        f_ra, f_rb, f_rc;
    logic [CTRL_W-1:0] f_op;
    logic              f_wide;
    logic [DATA_W-1:0] f_data;

    logic [SEL_W-1:0]  enable_nxt, bus_nxt;
    logic              md_read_nxt, inc_pc_nxt, busy_nxt, done_nxt, err_nxt;
    logic [CTRL_W-1:0] alu_nxt;
    logic [DATA_W-1:0] mdata_nxt;

    function automatic logic [SEL_W-1:0] onehot(input logic [4:0] idx);
        logic [SEL_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign accept = (state == S_IDLE) && start;
    assign bad    = ({1'b0, ra} >= NREGS) ||
                    (!mode && (({1'b0, rb} >= NREGS) || ({1'b0, rc} >= NREGS)));

    // Outputs are computed for the upcoming state, so on the accept edge the
    // fields must come straight from the inputs rather than the latches.
    assign f_ra   = accept ? ra        : ra_q;
    assign f_rb   = accept ? rb        : rb_q;
    assign f_rc   = accept ? rc        : rc_q;
    assign f_op   = accept ? alu_op    : op_q;
    assign f_wide = accept ? wide      : wide_q;
    assign f_data = accept ? load_data : data_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && !bad) state_nxt = mode ? S_LA : S_T0;
            S_LA:    state_nxt = S_LB;
            S_LB:    state_nxt = S_IDLE;
            S_T0:    state_nxt = S_T1;
            S_T1:    state_nxt = S_T2;
            S_T2:    state_nxt = S_T3;
            S_T3:    state_nxt = S_T4;
            S_T4:    state_nxt = S_T5;
            S_T5:    state_nxt = wide_q ? S_T6 : S_IDLE;
            S_T6:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ra_q   <= '0;
            rb_q   <= '0;
            rc_q   <= '0;
            op_q   <= '0;
            wide_q <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            ra_q   <= ra;
            rb_q   <= rb;
            rc_q   <= rc;
            op_q   <= alu_op;
            wide_q <= wide;
            data_q <= load_data;
        end
    end

    always_comb begin
        enable_nxt  = '0;
        bus_nxt     = '0;
        md_read_nxt = 1'b0;
        inc_pc_nxt  = 1'b0;
        alu_nxt     = '0;
        mdata_nxt   = '0;
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state != S_IDLE) && (state_nxt == S_IDLE);
        err_nxt     = accept ? bad : err;
        case (state_nxt)
            S_LA: begin
                mdata_nxt         = f_data;
                md_read_nxt       = 1'b1;
                enable_nxt[B_MDR] = 1'b1;
            end
            S_LB: begin
                bus_nxt[B_MDR] = 1'b1;
                enable_nxt     = onehot(f_ra);
            end
            S_T0: begin
                bus_nxt[B_PC]      = 1'b1;
                enable_nxt[EN_MAR] = 1'b1;
                enable_nxt[B_PC]   = 1'b1;
                inc_pc_nxt         = 1'b1;
            end
            S_T1: begin
                md_read_nxt       = 1'b1;
                enable_nxt[B_MDR] = 1'b1;
            end
            S_T2: begin
                bus_nxt[B_MDR]    = 1'b1;
                enable_nxt[EN_IR] = 1'b1;
            end
            S_T3: begin
                bus_nxt          = onehot(f_rb);
                enable_nxt[EN_Y] = 1'b1;
            end
            S_T4: begin
                bus_nxt          = onehot(f_rc);
                enable_nxt[EN_Z] = 1'b1;
                alu_nxt          = f_op;
            end
            S_T5: begin
                bus_nxt[BS_ZLO] = 1'b1;
                alu_nxt         = f_op;
                if (f_wide) enable_nxt[EN_LO] = 1'b1;
                else        enable_nxt        = onehot(f_ra);
            end
            S_T6: begin
                bus_nxt[BS_ZHI]   = 1'b1;
                enable_nxt[EN_HI] = 1'b1;
                alu_nxt           = f_op;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            enable     <= '0;
            bus_select <= '0;
            md_read    <= 1'b0;
            inc_pc     <= 1'b0;
            alu_ctrl   <= '0;
            mdata_out  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            enable     <= enable_nxt;
            bus_select <= bus_nxt;
            md_read    <= md_read_nxt;
            inc_pc     <= inc_pc_nxt;
            alu_ctrl   <= alu_nxt;
            mdata_out  <= mdata_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

endmodule
